// File: rtl/wb_cpu_bus_bridge.sv
// Bridges the core's valid/ready memory request bus onto a Wishbone B4 classic master port.
// One request is latched, framed with cyc/stb, and answered by ack, err or timeout.
module wb_cpu_bus_bridge #(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter bit          ALIGN_ADDR     = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cpu_valid_i,
   input  logic                    cpu_we_i,
   input  logic [ADDR_WIDTH-1:0]   cpu_addr_i,
   input  logic [DATA_WIDTH-1:0]   cpu_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] cpu_wstrb_i,
   output logic [DATA_WIDTH-1:0]   cpu_rdata_o,
   output logic                    cpu_ready_o,
   output logic                    cpu_err_o,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i,
   input  logic                    wb_err_i,
   output logic [31:0]             txn_count_o
);

   localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } state_t;

   state_t              state;
   logic [TW-1:0]       to_cnt;
   logic                timeout_hit;
   logic [ADDR_WIDTH-1:0] adr_next;

   always_comb begin
      adr_next = cpu_addr_i;
      if (ALIGN_ADDR) begin
         adr_next[1:0] = 2'b00;
      end
   end

   // to_cnt holds the number of completed BUS cycles without a response
   always_comb begin
      timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         to_cnt      <= '0;
         cpu_rdata_o <= '0;
         cpu_ready_o <= 1'b0;
         cpu_err_o   <= 1'b0;
         wb_cyc_o    <= 1'b0;
         wb_stb_o    <= 1'b0;
         wb_we_o     <= 1'b0;
         wb_sel_o    <= '0;
         wb_adr_o    <= '0;
         wb_dat_o    <= '0;
         txn_count_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               cpu_ready_o <= 1'b0;
               cpu_err_o   <= 1'b0;
               if (cpu_valid_i) begin
                  wb_we_o  <= cpu_we_i;
                  wb_adr_o <= adr_next;
                  wb_dat_o <= cpu_wdata_i;
                  wb_sel_o <= cpu_wstrb_i;
                  wb_cyc_o <= 1'b1;
                  wb_stb_o <= 1'b1;
                  to_cnt   <= '0;
                  state    <= BUS;
               end
            end

            BUS: begin
               // err outranks ack; both outrank the timeout on the final cycle
               if (wb_err_i) begin
                  wb_cyc_o    <= 1'b0;
                  wb_stb_o    <= 1'b0;
                  cpu_ready_o <= 1'b1;
                  cpu_err_o   <= 1'b1;
                  state       <= RESP;
               end else if (wb_ack_i) begin
                  if (!wb_we_o) begin
                     cpu_rdata_o <= wb_dat_i;
                  end
                  txn_count_o <= txn_count_o + 32'd1;
                  wb_cyc_o    <= 1'b0;
                  wb_stb_o    <= 1'b0;
                  cpu_ready_o <= 1'b1;
                  cpu_err_o   <= 1'b0;
                  state       <= RESP;
               end else if (timeout_hit) begin
                  cpu_rdata_o <= '0;
                  wb_cyc_o    <= 1'b0;
                  wb_stb_o    <= 1'b0;
                  cpu_ready_o <= 1'b1;
                  cpu_err_o   <= 1'b1;
                  state       <= RESP;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end

            RESP: begin
               cpu_ready_o <= 1'b0;
               cpu_err_o   <= 1'b0;
               state       <= IDLE;
            end

            default: begin
               cpu_ready_o <= 1'b0;
               cpu_err_o   <= 1'b0;
               wb_cyc_o    <= 1'b0;
               wb_stb_o    <= 1'b0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wb_cpu_bus_bridge.sv
// Table-driven bench for wb_cpu_bus_bridge with a response scoreboard on cpu_ready_o.
// A second instance with the timeout disabled checks that the bus is held indefinitely.
module tb_wb_cpu_bus_bridge;

   localparam int unsigned K_ACK  = 0;
   localparam int unsigned K_ERR  = 1;
   localparam int unsigned K_BOTH = 2;
   localparam int unsigned K_NONE = 3;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      int unsigned wait_n;
      int unsigned kind;
      logic [31:0] slave_dat;
      logic [31:0] exp_adr;
      logic        exp_err;
      int unsigned exp_cycles;
   } vec_t;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic [31:0] txn;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_valid, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata;
   logic [3:0]  cpu_wstrb;
   logic [31:0] cpu_rdata;
   logic        cpu_ready, cpu_err;
   logic        wb_cyc, wb_stb, wb_we;
   logic [3:0]  wb_sel;
   logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
   logic        wb_ack, wb_err;
   logic [31:0] txn_count;

   logic        nt_valid, nt_ack, nt_err;
   logic [31:0] nt_rdata, nt_adr, nt_dat_o, nt_txn;
   logic        nt_ready, nt_err_o, nt_cyc, nt_stb, nt_we;
   logic [3:0]  nt_sel;

   int   n_vec  = 0;
   int   n_miss = 0;
   exp_t sb[$];
   vec_t vecs[8];

   logic [31:0] exp_rdata;
   logic [31:0] exp_txn;

   always #5 clk = ~clk;

   wb_cpu_bus_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8), .ALIGN_ADDR(1'b1)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_valid_i(cpu_valid), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
      .cpu_wdata_i(cpu_wdata), .cpu_wstrb_i(cpu_wstrb),
      .cpu_rdata_o(cpu_rdata), .cpu_ready_o(cpu_ready), .cpu_err_o(cpu_err),
      .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_sel_o(wb_sel),
      .wb_adr_o(wb_adr), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(wb_ack), .wb_err_i(wb_err), .txn_count_o(txn_count)
   );

   wb_cpu_bus_bridge #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(0), .ALIGN_ADDR(1'b1)
   ) dut_nt (
      .clk(clk), .rst_n(rst_n),
      .cpu_valid_i(nt_valid), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr),
      .cpu_wdata_i(cpu_wdata), .cpu_wstrb_i(cpu_wstrb),
      .cpu_rdata_o(nt_rdata), .cpu_ready_o(nt_ready), .cpu_err_o(nt_err_o),
      .wb_cyc_o(nt_cyc), .wb_stb_o(nt_stb), .wb_we_o(nt_we), .wb_sel_o(nt_sel),
      .wb_adr_o(nt_adr), .wb_dat_o(nt_dat_o), .wb_dat_i(wb_dat_i),
      .wb_ack_i(nt_ack), .wb_err_i(nt_err), .txn_count_o(nt_txn)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every ready pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n === 1'b1 && cpu_ready === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL unexpected_ready: got ready=1 with no request outstanding (t=%0t)", $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_rdata", cpu_rdata, e.rdata);
            chk("resp_err", {31'd0, cpu_err}, {31'd0, e.err});
            chk("resp_txn", txn_count, e.txn);
         end
      end
   end

   task automatic run_vec(input vec_t v);
      int unsigned n;
      logic        bad;
      exp_t        e;
      @(negedge clk);
      cpu_valid = 1'b1;
      cpu_we    = v.we;
      cpu_addr  = v.addr;
      cpu_wdata = v.wdata;
      cpu_wstrb = v.wstrb;
      case (v.kind)
         K_ACK: begin
            if (!v.we) exp_rdata = v.slave_dat;
            exp_txn = exp_txn + 32'd1;
         end
         K_NONE: exp_rdata = 32'd0;
         default: ;
      endcase
      e.rdata = exp_rdata;
      e.err   = v.exp_err;
      e.txn   = exp_txn;
      sb.push_back(e);
      @(negedge clk);
      cpu_valid = 1'b0;
      cpu_addr  = ~v.addr;
      cpu_wdata = ~v.wdata;
      cpu_wstrb = ~v.wstrb;
      cpu_we    = ~v.we;
      n   = 0;
      bad = 1'b0;
      while (wb_cyc === 1'b1 && n < 50) begin
         if (wb_stb !== 1'b1 || wb_adr !== v.exp_adr || wb_dat_o !== v.wdata ||
             wb_sel !== v.wstrb || wb_we !== v.we)
            bad = 1'b1;
         wb_dat_i = ~v.slave_dat;
         if (v.kind != K_NONE && n == v.wait_n) begin
            wb_dat_i = v.slave_dat;
            wb_ack   = (v.kind == K_ACK || v.kind == K_BOTH);
            wb_err   = (v.kind == K_ERR || v.kind == K_BOTH);
         end
         n++;
         @(negedge clk);
         wb_ack = 1'b0;
         wb_err = 1'b0;
      end
      chk("bus_hold", {31'd0, bad}, 32'd0);
      chk("bus_cycles", n, v.exp_cycles);
      chk("ready_in_resp", {31'd0, cpu_ready}, 32'd1);
      @(negedge clk);
      chk("ready_one_cycle", {30'd0, cpu_ready, cpu_err}, 32'd0);
   endtask

   initial begin
      logic bad;
      int   pulses;
      vecs[0] = '{1'b0, 32'h0000_1006, 32'h0,         4'hF,    0, K_ACK,  32'hDEAD_BEEF, 32'h0000_1004, 1'b0, 1};
      vecs[1] = '{1'b1, 32'h0000_2000, 32'h1234_5678, 4'b0011, 3, K_ACK,  32'h5555_5555, 32'h0000_2000, 1'b0, 4};
      vecs[2] = '{1'b0, 32'h0000_3003, 32'h0,         4'hF,    1, K_BOTH, 32'h1111_1111, 32'h0000_3000, 1'b1, 2};
      vecs[3] = '{1'b0, 32'h0000_0041, 32'h0,         4'hF,    0, K_NONE, 32'h2222_2222, 32'h0000_0040, 1'b1, 8};
      vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'h0,         4'b1000, 2, K_ACK,  32'hA5A5_5A5A, 32'hFFFF_FFFC, 1'b0, 3};
      vecs[5] = '{1'b1, 32'h0000_5001, 32'hCAFE_0001, 4'b0100, 0, K_ERR,  32'h3333_3333, 32'h0000_5000, 1'b1, 1};
      vecs[6] = '{1'b0, 32'h0000_0600, 32'h0,         4'hF,    6, K_ACK,  32'h600D_CAFE, 32'h0000_0600, 1'b0, 7};
      vecs[7] = '{1'b0, 32'h0000_0702, 32'h0,         4'hF,    7, K_ACK,  32'h0BAD_F00D, 32'h0000_0700, 1'b0, 8};

      rst_n = 1'b0;
      cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_wstrb = '0;
      wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0;
      nt_valid = 1'b0; nt_ack = 1'b0; nt_err = 1'b0;
      exp_rdata = '0;
      exp_txn   = '0;
      repeat (3) @(negedge clk);
      chk("rst_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
      chk("rst_ready_err", {30'd0, cpu_ready, cpu_err}, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      chk("rst_txn", txn_count, 32'd0);
      chk("rst_wb_adr", wb_adr, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);
      chk("txn_after_table", txn_count, 32'd5);

      // Back-to-back reads with valid held and ack held high, including IDLE/RESP
      cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0900;
      for (int j = 0; j < 3; j++) begin
         exp_t e;
         exp_rdata = 32'hC0DE_0001 + 32'(3 * j);
         exp_txn   = exp_txn + 32'd1;
         e.rdata = exp_rdata; e.err = 1'b0; e.txn = exp_txn;
         sb.push_back(e);
      end
      pulses = 0;
      for (int i = 0; i < 9; i++) begin
         wb_dat_i = 32'hC0DE_0000 + 32'(i);
         wb_ack   = 1'b1;
         @(negedge clk);
         if (cpu_ready === 1'b1) pulses++;
      end
      cpu_valid = 1'b0;
      wb_ack    = 1'b0;
      chk("b2b_pulses", pulses, 32'd3);
      chk("b2b_txn", txn_count, 32'd8);
      repeat (2) @(negedge clk);
      chk("b2b_idle", {31'd0, wb_cyc}, 32'd0);

      // Asynchronous reset in the middle of a bus cycle
      cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0800;
      @(negedge clk);
      cpu_valid = 1'b0;
      chk("pre_rst_cyc", {31'd0, wb_cyc}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_cyc_stb", {30'd0, wb_cyc, wb_stb}, 32'd0);
      chk("arst_ready", {31'd0, cpu_ready}, 32'd0);
      chk("arst_txn", txn_count, 32'd0);
      chk("arst_rdata", cpu_rdata, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_txn   = '0;
      exp_rdata = '0;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", {31'd0, wb_cyc}, 32'd0);
      run_vec(vecs[0]);
      chk("post_rst_txn", txn_count, 32'd1);

      // Timeout disabled: bus must stay held while the slave is silent
      nt_valid = 1'b1;
      @(negedge clk);
      nt_valid = 1'b0;
      bad = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         if (nt_cyc !== 1'b1 || nt_stb !== 1'b1 || nt_ready !== 1'b0) bad = 1'b1;
         @(negedge clk);
      end
      chk("nt_hold_2000", {31'd0, bad}, 32'd0);
      chk("nt_txn", nt_txn, 32'd0);

      chk("sb_drained", sb.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/wb_cpu_bus_bridge.md
Name: wb_cpu_bus_bridge

Overview:
- Bridges the core's simple valid/ready memory bus (busValid/busReady/busWriteEnable/address/dataIn/dataOut) to a Wishbone B4 classic master port, which feeds the Controller's core_* bus.
- Replaces the ad-hoc one-cycle ack/data re-registering in the top level with:
  - a proper request latch;
  - cycle-accurate cyc/stb framing;
  - error and timeout handling;
  - a completed-transaction counter.

Parameters:
- ADDR_WIDTH, 32, width of address on both sides.
- DATA_WIDTH, 32, width of data on both sides.
- TIMEOUT_CYCLES, 1024, cycles in BUS before abort. 0 disables the timeout.
- ALIGN_ADDR, 1, when 1, wb_adr_o[1:0] is forced to 0.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  asynchronous, active-low reset
- cpu_valid_i  input  1  core request valid
- cpu_we_i  input  1  1 = write, 0 = read
- cpu_addr_i  input  ADDR_WIDTH  request address
- cpu_wdata_i  input  DATA_WIDTH  write data
- cpu_wstrb_i  input  DATA_WIDTH/8  byte enables
- cpu_rdata_o  output  DATA_WIDTH  read data returned to core
- cpu_ready_o  output  1  one-cycle completion pulse
- cpu_err_o  output  1  completion was bus error or timeout (valid with ready)
- wb_cyc_o  output  1  Wishbone cycle
- wb_stb_o  output  1  Wishbone strobe
- wb_we_o  output  1  Wishbone write enable
- wb_sel_o  output  DATA_WIDTH/8  Wishbone byte select
- wb_adr_o  output  ADDR_WIDTH  Wishbone address
- wb_dat_o  output  DATA_WIDTH  Wishbone write data
- wb_dat_i  input  DATA_WIDTH  Wishbone read data
- wb_ack_i  input  1  Wishbone acknowledge
- wb_err_i  input  1  Wishbone error
- txn_count_o  output  32  count of transactions completed with ack, wraps modulo 2^32

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, including cpu_rdata_o and txn_count_o.
  - Timeout counter cleared.
  - Reset assertion mid-transaction drops wb_cyc_o/wb_stb_o immediately; no ready pulse is produced.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - If cpu_valid_i=1 at an edge, latch we/addr/wdata/wstrb, clear the timeout counter and go to BUS.
  - wb_cyc_o=wb_stb_o=1 from the next cycle (1-cycle request latency).
  - Address output: when ALIGN_ADDR=1, wb_adr_o = {addr[ADDR_WIDTH-1:2], 2'b00}.
- BUS:
  - wb_cyc_o=wb_stb_o=1 and all wb_* outputs are held stable from the latch; CPU inputs changing here are ignored.
  - Each cycle without a response, the timeout counter increments.
  - wb_ack_i=1 → read: cpu_rdata_o <= wb_dat_i. Write: cpu_rdata_o unchanged. In both cases txn_count_o += 1 and go to RESP.
  - wb_err_i=1 → cpu_err_o set for the response, txn_count_o unchanged, go to RESP. If ack and err are high together, err wins.
  - Timeout: if TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 with no ack/err, abort. Response is cpu_err_o=1, cpu_rdata_o=0, go to RESP.
  - cyc/stb deassert on the edge that leaves BUS (registered). An ack in the first BUS cycle (zero-wait slave) is accepted.
- RESP:
  - cpu_ready_o=1 for exactly one cycle; cpu_err_o is valid only in this cycle and 0 otherwise.
  - cpu_valid_i is ignored; the state returns to IDLE.
  - A valid still high in IDLE starts a new transaction, so the minimum cost is 3 cycles per access.
- Stray responses: wb_ack_i/wb_err_i outside BUS are ignored and have no effect on state or counters.
- cpu_rdata_o holds its last value until the next read completion or timeout.

Test Plan:
- Zero-wait read: valid, we=0, addr=0x0000_1006; ack in the first BUS cycle with wb_dat_i=0xDEADBEEF → wb_adr_o=0x0000_1004, cyc high 1 cycle, cpu_ready_o pulse 2 cycles after accept, cpu_rdata_o=0xDEADBEEF, txn_count_o=1.
- Waited write: we=1, wdata=0x12345678, wstrb=4'b0011, ack after 3 wait cycles → wb_dat_o/wb_sel_o stable for all 4 BUS cycles, ready=1 with err=0, cpu_rdata_o unchanged.
- Error: read with wb_err_i=1 and wb_ack_i=1 in the same cycle → cpu_ready_o=1 with cpu_err_o=1, txn_count_o not incremented.
- Timeout: TIMEOUT_CYCLES=8, slave never responds → cyc drops after 8 BUS cycles, ready+err pulse, cpu_rdata_o=0. Repeat with TIMEOUT_CYCLES=0 → bus stays held for 2000 cycles.
- Back-to-back: cpu_valid_i held high for 3 reads with zero-wait slave → exactly 3 ready pulses in 9 cycles, stray wb_ack_i in IDLE ignored, txn_count_o=3.
- Reset mid-BUS: rst_n low while cyc=1 → wb_cyc_o, wb_stb_o, cpu_ready_o and txn_count_o are 0 asynchronously; after release state is IDLE.
